regf_wb_sched: RTL and testbench

//  Write-back scheduler directly upstream of the 8x8 two-write-port register file.

---
 rtl/regf_pkg.sv | 18 +
 rtl/regf_wb_fifo.sv | 83 ++++++++
 rtl/regf_wb_sched.sv | 165 ++++++++++++++++
 tb/tb_regf_wb_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regf_pkg.sv
// Shared register-file definitions: geometry constants, the write-back request
// record, and a one-hot register decode used by hazard tracking.
package regf_pkg;

    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] a);
        return NREG'(1) << a;
    endfunction

endpackage

// File: rtl/regf_wb_fifo.sv
// Two-push / two-pop circular buffer for write-back requests. Exposes the two
// oldest entries, a per-slot valid map and the raw storage so the owner can
// build hazard information without a second copy of the queue.
module regf_wb_fifo
    import regf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_push0,
    input  logic                         i_push1,
    input  logic [AW+DW-1:0]             i_din0,
    input  logic [AW+DW-1:0]             i_din1,
    input  logic [1:0]                   i_pop,
    output logic [AW+DW-1:0]             o_head,
    output logic [AW+DW-1:0]             o_head1,
    output logic                         o_head_vld,
    output logic                         o_head1_vld,
    output logic [$clog2(DEPTH):0]       o_level,
    output logic [DEPTH-1:0]             o_slot_vld,
    output logic [DEPTH*(AW+DW)-1:0]     o_entries
);

    localparam int unsigned EW = AW + DW;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;

    logic [1:0]    w_npush;
    logic [EW-1:0] w_first;
    logic [PW-1:0] w_wptr1;
    logic [PW-1:0] w_rptr1;

    // A lone req1 is compacted into the first free slot.
    assign w_npush = {1'b0, i_push0} + {1'b0, i_push1};
    assign w_first = i_push0 ? i_din0 : i_din1;
    assign w_wptr1 = r_wptr + PW'(1);
    assign w_rptr1 = r_rptr + PW'(1);

    // Storage writes; no reset needed since validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (w_npush != 2'd0) r_mem[r_wptr] <= w_first;
        if (i_push0 && i_push1) r_mem[w_wptr1] <= i_din1;
    end

    // Pointer and occupancy update; flush wins over any pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_npush);
            r_rptr  <= r_rptr + PW'(i_pop);
            r_level <= r_level + LW'(w_npush) - LW'(i_pop);
        end
    end

    assign o_head      = r_mem[r_rptr];
    assign o_head1     = r_mem[w_rptr1];
    assign o_head_vld  = (r_level != '0);
    assign o_head1_vld = (r_level >= LW'(2));
    assign o_level     = r_level;

    // Slot is live when its distance from the read pointer is below occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PW-1:0] w_off;
        assign w_off                  = PW'(g) - r_rptr;
        assign o_slot_vld[g]          = ({1'b0, w_off} < r_level);
        assign o_entries[g*EW +: EW]  = r_mem[g];
    end

endmodule

// File: rtl/regf_wb_sched.sv
// Write-back scheduler in front of the two-write-port register file. Queues up
// to two requests per cycle, issues the two oldest per cycle unless they hit
// the same register, and publishes a pending-write bitmap for RAW stalls.
// Build option: define WB_COALESCE_EN to merge a same-address head pair into
// a single write of the younger data.
module regf_wb_sched
    import regf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   req0_valid,
    input  logic [AW-1:0]          req0_addr,
    input  logic [DW-1:0]          req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [AW-1:0]          req1_addr,
    input  logic [DW-1:0]          req1_data,
    output logic                   req1_ready,
    output logic                   wr0,
    output logic [AW-1:0]          addr0,
    output logic [DW-1:0]          din0,
    output logic                   wr1,
    output logic [AW-1:0]          addr1,
    output logic [DW-1:0]          din1,
    output logic [NREG-1:0]        pending,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned EW = AW + DW;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    wb_req_t              w_head;
    wb_req_t              w_head1;
    logic                 w_head_vld;
    logic                 w_head1_vld;
    logic [LW-1:0]        w_level;
    logic [DEPTH-1:0]     w_slot_vld;
    logic [DEPTH*EW-1:0]  w_entries;
    logic                 w_push0;
    logic                 w_push1;
    logic [1:0]           w_pop;
    logic                 w_same;

    logic                 r_wr0, r_wr1;
    logic [AW-1:0]        r_addr0, r_addr1;
    logic [DW-1:0]        r_din0, r_din1;
    logic                 w_wr0_nxt, w_wr1_nxt;
    logic [AW-1:0]        w_addr0_nxt, w_addr1_nxt;
    logic [DW-1:0]        w_din0_nxt, w_din1_nxt;
    logic [NREG-1:0]      w_pending;

    // Credit is taken from registered occupancy only; same-cycle pops don't count.
    assign req0_ready = !flush && (w_level < LW'(DEPTH));
    assign req1_ready = !flush && (w_level < LW'(DEPTH - 1));
    assign w_push0    = req0_valid && req0_ready;
    assign w_push1    = req1_valid && req1_ready;
    assign w_same     = (w_head.addr == w_head1.addr);

    regf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_push0     (w_push0),
        .i_push1     (w_push1),
        .i_din0      ({req0_addr, req0_data}),
        .i_din1      ({req1_addr, req1_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_head1     (w_head1),
        .o_head_vld  (w_head_vld),
        .o_head1_vld (w_head1_vld),
        .o_level     (w_level),
        .o_slot_vld  (w_slot_vld),
        .o_entries   (w_entries)
    );

    // Issue selection: head on port 0, head+1 on port 1 when addresses differ.
    always_comb begin
        w_wr0_nxt   = 1'b0;
        w_wr1_nxt   = 1'b0;
        w_addr0_nxt = r_addr0;
        w_din0_nxt  = r_din0;
        w_addr1_nxt = r_addr1;
        w_din1_nxt  = r_din1;
        w_pop       = 2'd0;
        if (w_head_vld) begin
            w_wr0_nxt   = 1'b1;
            w_addr0_nxt = w_head.addr;
            w_din0_nxt  = w_head.data;
            w_pop       = 2'd1;
            if (w_head1_vld) begin
`ifdef WB_COALESCE_EN
                if (w_same) begin
                    // Older write is dead; only the younger data reaches the file.
                    w_addr0_nxt = w_head1.addr;
                    w_din0_nxt  = w_head1.data;
                    w_pop       = 2'd2;
                end else begin
                    w_wr1_nxt   = 1'b1;
                    w_addr1_nxt = w_head1.addr;
                    w_din1_nxt  = w_head1.data;
                    w_pop       = 2'd2;
                end
`else
                // Same address stays queued so the older write lands first.
                if (!w_same) begin
                    w_wr1_nxt   = 1'b1;
                    w_addr1_nxt = w_head1.addr;
                    w_din1_nxt  = w_head1.data;
                    w_pop       = 2'd2;
                end
`endif
            end
        end
    end

    // Registered write ports; flush kills the enables but keeps address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr0   <= 1'b0;
            r_wr1   <= 1'b0;
            r_addr0 <= '0;
            r_addr1 <= '0;
            r_din0  <= '0;
            r_din1  <= '0;
        end else if (flush) begin
            r_wr0   <= 1'b0;
            r_wr1   <= 1'b0;
        end else begin
            r_wr0   <= w_wr0_nxt;
            r_wr1   <= w_wr1_nxt;
            r_addr0 <= w_addr0_nxt;
            r_addr1 <= w_addr1_nxt;
            r_din0  <= w_din0_nxt;
            r_din1  <= w_din1_nxt;
        end
    end

    // Pending bitmap: every queued destination plus writes currently issuing.
    always_comb begin
        w_pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_slot_vld[i]) begin
                w_pending = w_pending | reg_onehot(w_entries[i*EW + DW +: AW]);
            end
        end
        if (r_wr0) w_pending = w_pending | reg_onehot(r_addr0);
        if (r_wr1) w_pending = w_pending | reg_onehot(r_addr1);
    end

    assign wr0     = r_wr0;
    assign wr1     = r_wr1;
    assign addr0   = r_addr0;
    assign addr1   = r_addr1;
    assign din0    = r_din0;
    assign din1    = r_din1;
    assign pending = w_pending;
    assign level   = w_level;

endmodule

// File: tb/tb_regf_wb_sched.sv
// Scoreboard bench for regf_wb_sched: a queue-level model predicts readiness,
// issued writes, occupancy and the pending bitmap; a monitor checks each cycle.
module tb_regf_wb_sched;
    import regf_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0]   req0_addr = '0, req1_addr = '0;
    logic [DW-1:0]   req0_data = '0, req1_data = '0;
    logic            req0_ready, req1_ready;
    logic            wr0, wr1;
    logic [AW-1:0]   addr0, addr1;
    logic [DW-1:0]   din0, din1;
    logic [NREG-1:0] pending;
    logic [LW-1:0]   level;

    always #5 clk = ~clk;

    regf_wb_sched #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr0        (wr0),
        .addr0      (addr0),
        .din0       (din0),
        .wr1        (wr1),
        .addr1      (addr1),
        .din1       (din1),
        .pending    (pending),
        .level      (level)
    );

    typedef struct {
        bit [AW-1:0] a;
        bit [DW-1:0] d;
    } ent_t;

    typedef struct {
        bit          wr0;
        bit [AW-1:0] a0;
        bit [DW-1:0] d0;
        bit          wr1;
        bit [AW-1:0] a1;
        bit [DW-1:0] d1;
    } out_t;

    ent_t mq[$];      // model of queued requests, oldest first
    out_t eq[$];      // expected write-port state, one per clock edge
    out_t last_out;   // port values held when nothing issues
    out_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [NREG-1:0] model_pending(input out_t o);
        bit [NREG-1:0] p = '0;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        if (o.wr0) p[o.a0] = 1'b1;
        if (o.wr1) p[o.a1] = 1'b1;
        return p;
    endfunction

    // Monitor: after every edge compare ports, occupancy and hazards.
    always @(negedge clk) begin
        if (mon_en && eq.size() > 0) begin
            mon_e = eq.pop_front();
            chk("wr0",     32'(wr0),     32'(mon_e.wr0));
            chk("addr0",   32'(addr0),   32'(mon_e.a0));
            chk("din0",    32'(din0),    32'(mon_e.d0));
            chk("wr1",     32'(wr1),     32'(mon_e.wr1));
            chk("addr1",   32'(addr1),   32'(mon_e.a1));
            chk("din1",    32'(din1),    32'(mon_e.d1));
            chk("level",   32'(level),   32'(mq.size()));
            chk("pending", 32'(pending), 32'(model_pending(mon_e)));
        end
    end

    // One clock of stimulus plus the model step for that edge.
    task automatic cycle(input bit v0, input bit [AW-1:0] a0, input bit [DW-1:0] d0,
                         input bit v1, input bit [AW-1:0] a1, input bit [DW-1:0] d1,
                         input bit fl);
        bit   r0, r1;
        ent_t h, s;
        out_t o;
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        flush = fl;
        #1;
        r0 = !fl && (mq.size() + 1 <= DEPTH);
        r1 = !fl && (mq.size() + 2 <= DEPTH);
        chk("req0_ready", 32'(req0_ready), 32'(r0));
        chk("req1_ready", 32'(req1_ready), 32'(r1));
        @(posedge clk);
        o = last_out;
        o.wr0 = 1'b0;
        o.wr1 = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() > 0) begin
                h = mq.pop_front();
                o.wr0 = 1'b1; o.a0 = h.a; o.d0 = h.d;
                if (mq.size() > 0) begin
`ifdef WB_COALESCE_EN
                    s = mq.pop_front();
                    if (s.a == h.a) begin
                        o.a0 = s.a; o.d0 = s.d;
                    end else begin
                        o.wr1 = 1'b1; o.a1 = s.a; o.d1 = s.d;
                    end
`else
                    if (mq[0].a != h.a) begin
                        s = mq.pop_front();
                        o.wr1 = 1'b1; o.a1 = s.a; o.d1 = s.d;
                    end
`endif
                end
            end
            if (v0 && r0) mq.push_back('{a: a0, d: d0});
            if (v1 && r1) mq.push_back('{a: a1, d: d1});
        end
        last_out = o;
        eq.push_back(o);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic check_reset_state();
        chk("rst wr0",     32'(wr0),     32'd0);
        chk("rst wr1",     32'(wr1),     32'd0);
        chk("rst addr0",   32'(addr0),   32'd0);
        chk("rst din0",    32'(din0),    32'd0);
        chk("rst addr1",   32'(addr1),   32'd0);
        chk("rst din1",    32'(din1),    32'd0);
        chk("rst level",   32'(level),   32'd0);
        chk("rst pending", 32'(pending), 32'd0);
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        check_reset_state();
        mq.delete();
        eq.delete();
        last_out = '{default: 0};
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit          v0, v1, fl;
        bit [AW-1:0] a0, a1;
        last_out = '{default: 0};
        #3;
        check_reset_state();
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Single write to r3.
        cycle(1'b1, 3'd3, 8'hA5, 1'b0, '0, '0, 1'b0);
        idle(3);
        // Two distinct registers in one cycle.
        cycle(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0);
        idle(2);
        // Same register pair.
        cycle(1'b1, 3'd5, 8'h01, 1'b1, 3'd5, 8'h02, 1'b0);
        idle(3);
        // Lone req1.
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h44, 1'b0);
        idle(2);
        // Same-address chain to push occupancy up and wrap the pointers.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 3'd6, 8'(2*i), 1'b1, 3'd6, 8'(2*i + 1), 1'b0);
        end
        idle(8);
        // Flush with a backlog and a request presented.
        cycle(1'b1, 3'd7, 8'h70, 1'b1, 3'd7, 8'h71, 1'b0);
        cycle(1'b1, 3'd7, 8'h72, 1'b1, 3'd7, 8'h73, 1'b0);
        cycle(1'b1, 3'd2, 8'h99, 1'b0, '0, '0, 1'b1);
        idle(2);
        // Reset mid-burst with writes issuing, then normal traffic.
        cycle(1'b1, 3'd1, 8'hB1, 1'b1, 3'd2, 8'hB2, 1'b0);
        cycle(1'b1, 3'd3, 8'hB3, 1'b1, 3'd4, 8'hB4, 1'b0);
        async_reset();
        cycle(1'b1, 3'd3, 8'hC3, 1'b1, 3'd5, 8'hC5, 1'b0);
        idle(3);

        // Randomised traffic, with narrow address ranges to force collisions.
        for (int n = 0; n < 1500; n++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            a0 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 1)) : AW'($urandom);
            a1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 1)) : AW'($urandom);
            fl = ($urandom_range(0, 39) == 0);
            cycle(v0, a0, DW'($urandom), v1, a1, DW'($urandom), fl);
            if (n == 700) async_reset();
        end
        idle(8);
        @(negedge clk);
        #1;
        chk("drained level",   32'(level),   32'd0);
        chk("drained pending", 32'(pending), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
